// File: rtl/tdm_demux.sv
// tdm_demux: two-channel serial TDM demultiplexer.
//
// A frame is 2*W serial bits, MSB first: W bits of channel 0 followed by W bits
// of channel 1. Bits are consumed only on edges where STB is high. FRAME
// (qualified by STB) marks the first bit of channel 0. A FRAME seen mid-frame
// abandons the partial word, pulses ERR and restarts decoding on that bit.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   D      - serial data, MSB first
//   STB    - D valid and consumed on this edge
//   FRAME  - with STB: D is bit W-1 of channel 0
//   Y0/Y1  - last complete channel-0 / channel-1 word
//   V0/V1  - one-cycle pulse, Y0 / Y1 just updated
//   S      - 1 while receiving channel 1
//   ERR    - one-cycle pulse, frame resync occurred
module tdm_demux #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         D,
  input  logic         STB,
  input  logic         FRAME,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic         V0,
  output logic         V1,
  output logic         S,
  output logic         ERR
);

  // Count only needs 0..W-1: the W-th bit completes the word and clears it.
  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StCh0, StCh1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    y0_q, y0_d;
  logic [W-1:0]    y1_q, y1_d;
  logic            v0_q, v0_d;
  logic            v1_q, v1_d;
  logic            err_q, err_d;

  logic [W-1:0]    word;
  logic [W-1:0]    first_bit;
  logic            unused_shift_msb;

  // Word as it stands once the current D is shifted in.
  assign word      = {shift_q[W-2:0], D};
  assign first_bit = {{(W-1){1'b0}}, D};
  // The MSB is shifted out as D enters; the completed word is taken from word.
  assign unused_shift_msb = shift_q[W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    err_d   = 1'b0;

    if (STB) begin
      unique case (state_q)
        StIdle: begin
          if (FRAME) begin
            shift_d = first_bit;
            cnt_d   = OneCnt;
            state_d = StCh0;
          end
        end
        StCh0, StCh1: begin
          if (FRAME) begin
            // Resync: drop the partial word, this bit starts a new channel 0.
            err_d   = 1'b1;
            shift_d = first_bit;
            cnt_d   = OneCnt;
            state_d = StCh0;
          end else if (cnt_q == LastCnt) begin
            shift_d = word;
            cnt_d   = '0;
            if (state_q == StCh0) begin
              y0_d    = word;
              v0_d    = 1'b1;
              state_d = StCh1;
            end else begin
              y1_d    = word;
              v1_d    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + OneCnt;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      err_q   <= err_d;
    end
  end

  assign Y0  = y0_q;
  assign Y1  = y1_q;
  assign V0  = v0_q;
  assign V1  = v1_q;
  assign S   = (state_q == StCh1);
  assign ERR = err_q;

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the bits per channel slot (legal range W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port D, input, 1 bit: serial TDM data, MSB first.
REQ-005 The block SHALL have port STB, input, 1 bit: D is valid and consumed on this edge.
REQ-006 The block SHALL have port FRAME, input, 1 bit: sampled only with STB; marks D as bit W-1 of channel 0.
REQ-007 The block SHALL have port Y0, output, W bits: last complete channel-0 word.
REQ-008 The block SHALL have port Y1, output, W bits: last complete channel-1 word.
REQ-009 The block SHALL have port V0, output, 1 bit: one-cycle pulse, Y0 just updated.
REQ-010 The block SHALL have port V1, output, 1 bit: one-cycle pulse, Y1 just updated.
REQ-011 The block SHALL have port S, output, 1 bit: current slot select (0 = channel 0 or idle, 1 = channel 1).
REQ-012 The block SHALL have port ERR, output, 1 bit: one-cycle pulse, frame resync occurred.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, CH0 and CH1, plus a bit counter and a W-bit shift register, all registered.
REQ-014 In IDLE, the block SHALL ignore STB when FRAME=0.
REQ-015 In IDLE, an edge with STB=1 and FRAME=1 SHALL shift D in as bit W-1 of channel 0, set the count to 1, and move to CH0.
REQ-016 In CH0 and CH1, each edge with STB=1 and FRAME=0 SHALL shift D in (MSB first) and increment the count.
REQ-017 Edges with STB=0 SHALL hold all state; FRAME SHALL be ignored when STB=0.
REQ-018 On the edge that accepts the W-th channel-0 bit, the block SHALL load Y0 with the assembled word, drive V0=1 for exactly the following cycle, clear the count, and move to CH1.
REQ-019 On the edge that accepts the W-th channel-1 bit, the block SHALL load Y1, drive V1=1 for exactly the following cycle, and move to IDLE.
REQ-020 The edge-accepting latency SHALL be 0 cycles: Y and V SHALL be valid in the cycle immediately after the last bit's edge.
REQ-021 Y0 and Y1 SHALL hold their values until the next complete word in the same channel.
REQ-022 S SHALL be 1 exactly while the state is CH1.
REQ-023 An edge in CH0 or CH1 with STB=1 and FRAME=1 (any bit position, including the last) SHALL:
- discard the partial word;
- leave Y0, Y1, V0 and V1 unaffected by the partial word;
- drive ERR=1 for the following cycle;
- treat D as bit W-1 of a new channel 0, with the count set to 1 and the state set to CH0.
REQ-024 FRAME with STB in IDLE, including the cycle directly after the V1 edge, SHALL NOT raise ERR; back-to-back frames SHALL decode with no gap.
REQ-025 V0, V1 and ERR SHALL never be high in the same cycle except as given in REQ-026.
REQ-026 V1 and ERR SHALL never coincide; V0 and ERR SHALL never coincide.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force:
- state to IDLE;
- count, shift register, Y0 and Y1 to 0;
- V0, V1, S and ERR to 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without raising V0, V1 or ERR.
REQ-029 After rst_n rises, the first FRAME-qualified STB SHALL start a clean decode.

Verification (W=8)
REQ-030 The bench SHALL cover: assert rst_n=0 with random D/STB/FRAME -> Y0=Y1=0x00, and V0, V1, S, ERR all 0.
REQ-031 The bench SHALL cover: STB every cycle, FRAME on the first bit, bits 0xA5 then 0x3C -> Y0=0xA5 with V0 pulse after the 8th edge, S=1 for the next 8 edges, Y1=0x3C with V1 pulse after the 16th edge, ERR=0.
REQ-032 The bench SHALL cover: same frame with STB high one cycle in three -> identical Y0/Y1 values; each V pulse one cycle wide, directly after the accepting STB edge.
REQ-033 The bench SHALL cover: frame 0x11/0x22 with FRAME reasserted at channel-1 bit 5, then full frame 0x5A/0xC3 -> ERR pulse once, Y0=0x11 retained, Y1 not loaded until it becomes 0xC3, Y0 then 0x5A.
REQ-034 The bench SHALL cover: rst_n pulsed low after 12 bits of a frame, then full frame 0xFF/0x00 -> no V0/V1/ERR from the aborted frame, then Y0=0xFF and Y1=0x00.
REQ-035 The bench SHALL cover: two back-to-back frames 0x01/0x02 and 0x03/0x04, with FRAME on the edge right after the V1 edge -> four V pulses, ERR never asserted.
